ysyx_ifq: RTL and testbench

Instruction fetch queue between the IFU fetch logic and the IDU pipeline latch. It decouples fetch from decode back-pressure by buffering up to DEPTH fetched instructions, each with its pc, predicted next pc, and fetch-trap info. The queue is cleared on a pipeline flush. After it accepts a trapping fetch, it stops accepting further fetches until that flush arrives.

---
 rtl/ysyx_ifq_pkg.sv | 21 ++
 rtl/ysyx_ifq.sv | 98 +++++++++
 tb/tb_ysyx_ifq.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_ifq_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package ysyx_ifq_pkg;

    localparam int YSYX_XLEN      = 32;
    localparam int YSYX_IFQ_DEPTH = 4;

    // One fetched instruction together with its prediction and fault info.
    typedef struct packed {
        logic [31:0]          inst;
        logic [31:0]          pc;
        logic [YSYX_XLEN-1:0] pnpc;
        logic                 trap;
        logic [YSYX_XLEN-1:0] cause;
    } ifq_entry_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ifq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ysyx_ifq.sv
// Instruction fetch queue: circular buffer between IFU fetch and the IDU latch.
// Latency: 1 cycle enqueue-to-output, no bypass even when empty.
// Backpressure: in_ready depends only on registered state and flush_pipe, never on out_ready.
module ysyx_ifq
    import ysyx_ifq_pkg::*;
#(
    parameter int DEPTH = YSYX_IFQ_DEPTH,
    parameter int XLEN  = YSYX_XLEN
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush_pipe,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [31:0]            in_pc,
    input  logic [XLEN-1:0]        in_pnpc,
    input  logic                   in_trap,
    input  logic [XLEN-1:0]        in_cause,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_pc,
    output logic [XLEN-1:0]        out_pnpc,
    output logic                   out_trap,
    output logic [XLEN-1:0]        out_cause,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ifq_ptr_w(DEPTH);

    // Local copy of the entry layout so XLEN may be overridden per instance.
    typedef struct packed {
        logic [31:0]     inst;
        logic [31:0]     pc;
        logic [XLEN-1:0] pnpc;
        logic            trap;
        logic [XLEN-1:0] cause;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_e;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          trap_block;
    logic          empty;
    logic          full;
    logic          enq;
    logic          deq;

    assign empty     = (head == tail);
    assign full      = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign in_ready  = !full && !trap_block && !flush_pipe;
    assign out_valid = !empty && !flush_pipe;
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = tail - head;

    assign head_e    = mem[head[AW-1:0]];
    assign out_inst  = head_e.inst;
    assign out_pc    = head_e.pc;
    assign out_pnpc  = head_e.pnpc;
    assign out_trap  = head_e.trap;
    assign out_cause = head_e.cause;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            trap_block <= 1'b0;
        end else if (flush_pipe) begin
            head       <= '0;
            tail       <= '0;
            trap_block <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
                // A faulting fetch ends the useful stream until the redirect flush.
                if (in_trap) begin
                    trap_block <= 1'b1;
                end
            end
            if (deq) begin
                head <= head + PW'(1);
            end
        end
    end

    // Payload storage is not reset; it is only observed while out_valid is high.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[tail[AW-1:0]] <= '{inst: in_inst, pc: in_pc, pnpc: in_pnpc,
                                   trap: in_trap, cause: in_cause};
        end
    end

endmodule

// File: tb/tb_ysyx_ifq.sv
// Scenario bench for ysyx_ifq with an enqueue/dequeue scoreboard.
module tb_ysyx_ifq;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pnpc;
        logic        trap;
        logic [31:0] cause;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_pipe;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_pnpc;
    logic        in_trap;
    logic [31:0] in_cause;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pnpc;
    logic        out_trap;
    logic [31:0] out_cause;
    logic [2:0]  count;

    ent_t exp_q[$];
    ent_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ysyx_ifq #(.DEPTH(4), .XLEN(32)) dut (
        .clock(clock), .reset(reset), .flush_pipe(flush_pipe),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_pnpc(in_pnpc), .in_trap(in_trap), .in_cause(in_cause),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_pnpc(out_pnpc), .out_trap(out_trap), .out_cause(out_cause), .count(count)
    );

    always #5 clock = ~clock;

    // Records handshakes at the falling edge, then advances to just after the next rising edge.
    task automatic tick();
        ent_t e;
        @(negedge clock);
        if (in_valid && in_ready) begin
            e = {in_inst, in_pc, in_pnpc, in_trap, in_cause};
            exp_q.push_back(e);
        end
        if (out_valid && out_ready) begin
            e = {out_inst, out_pc, out_pnpc, out_trap, out_cause};
            obs_q.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic trap, input logic [31:0] cause);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = pc ^ 32'h0000_0013;
        in_pnpc  = pc + 32'd4;
        in_trap  = trap;
        in_cause = cause;
    endtask

    task automatic drain_wait();
        for (int k = 0; k < 12 && count != 3'd0; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b count=%0d in_ready=%b want 0/0/1",
                     out_valid, count, in_ready);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single(input string tag);
        ent_t e, o;
        out_ready = 1'b1;
        offer(32'h8000_0000, 1'b0, 32'h0);
        in_inst = 32'h0000_0013;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL %s_no_bypass: out_valid=%b count=%0d want 0/0", tag, out_valid, count);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || count !== 3'd1) begin
            n_err++;
            $display("FAIL %s_visible: out_valid=%b out_pc=%h count=%0d want 1/80000000/1",
                     tag, out_valid, out_pc, count);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL %s_drained: out_valid=%b count=%0d want 0/0", tag, out_valid, count);
        end
        n_cmp++;
        if (exp_q.size() != 1 || obs_q.size() != 1) begin
            n_err++;
            $display("FAIL %s_sb_size: got exp=%0d obs=%0d want 1/1", tag, exp_q.size(), obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s_data: got %h want %h", tag, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_fill();
        ent_t e, o;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(32'h8000_0000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        offer(32'h8000_0010, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL fill_held_off: count=%0d want 4", count);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_no_accept_on_deq: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        tick();
        tick();
        in_valid = 1'b0;
        drain_wait();
        n_cmp++;
        if (exp_q.size() != 5 || obs_q.size() != 5) begin
            n_err++;
            $display("FAIL fill_sb_size: got exp=%0d obs=%0d want 5/5", exp_q.size(), obs_q.size());
        end
        for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e || o.pc !== 32'h8000_0000 + 32'(4 * i)) begin
                n_err++;
                $display("FAIL fill_order[%0d]: got pc %h data %h want pc %h data %h",
                         i, o.pc, o, 32'h8000_0000 + 32'(4 * i), e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stream();
        ent_t e, o;
        int   bad_count = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(32'h9000_0000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 22; i++) begin
            offer(32'h9000_0000 + 32'(4 * i), 1'b0, 32'h0);
            #1;
            if (count !== 3'd2) bad_count++;
            tick();
        end
        n_cmp++;
        if (bad_count != 0) begin
            n_err++;
            $display("FAIL stream_count_const: %0d cycles with count != 2", bad_count);
        end
        in_valid = 1'b0;
        drain_wait();
        n_cmp++;
        if (exp_q.size() != 22 || obs_q.size() != 22) begin
            n_err++;
            $display("FAIL stream_sb_size: got exp=%0d obs=%0d want 22/22", exp_q.size(), obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL stream_order: got pc %h data %h want pc %h data %h", o.pc, o, e.pc, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'hA000_0000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        offer(32'hDEAD_0000, 1'b0, 32'h0);
        flush_pipe = 1'b1;
        out_ready  = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cycle: out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
        end
        tick();
        flush_pipe = 1'b0;
        in_valid   = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: count=%0d in_ready=%b out_valid=%b want 0/1/0",
                     count, in_ready, out_valid);
        end
        tick();
        tick();
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_no_output: got %0d entries out want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_trap();
        ent_t e, o;
        out_ready = 1'b0;
        offer(32'hB000_0000, 1'b0, 32'h0);
        tick();
        offer(32'hB000_0004, 1'b1, 32'h0000_000C);
        tick();
        offer(32'hB000_0008, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL trap_block: in_ready=%b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (count !== 3'd2) begin
            n_err++;
            $display("FAIL trap_held_off: count=%0d want 2", count);
        end
        out_ready = 1'b1;
        drain_wait();
        n_cmp++;
        if (in_ready !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL trap_after_drain: in_ready=%b count=%0d want 0/0", in_ready, count);
        end
        n_cmp++;
        if (exp_q.size() != 2 || obs_q.size() != 2) begin
            n_err++;
            $display("FAIL trap_sb_size: got exp=%0d obs=%0d want 2/2", exp_q.size(), obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL trap_data: got pc %h trap %b cause %h want pc %h trap %b cause %h",
                         o.pc, o.trap, o.cause, e.pc, e.trap, e.cause);
            end
        end
        in_valid   = 1'b0;
        flush_pipe = 1'b1;
        tick();
        flush_pipe = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL trap_cleared_by_flush: in_ready=%b want 1", in_ready);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(32'hC000_0000 + 32'(4 * i), 1'b0, 32'h0);
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_err++;
            $display("FAIL async_reset: out_valid=%b count=%0d want 0/0 before edge", out_valid, count);
        end
        exp_q.delete();
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        test_single("post_reset");
    endtask

    initial begin
        reset      = 1'b1;
        flush_pipe = 1'b0;
        in_valid   = 1'b0;
        in_inst    = '0;
        in_pc      = '0;
        in_pnpc    = '0;
        in_trap    = 1'b0;
        in_cause   = '0;
        out_ready  = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_single("single");
        test_fill();
        test_stream();
        test_flush();
        test_trap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
